alu_seq: RTL
============

# alu_seq

Parametrised, registered ALU for the datapath; the next generation of the 32-bit combinational ALU. It keeps the existing logic, add/sub and set-less-than opcodes and adds shifts, an unsigned compare, and iterative unsigned multiply and divide. Results are registered behind a start/busy/done handshake. It sits in the execute stage, and the controller stalls on `busy`.

## Interface

- `WIDTH`, default 32: operand/result width; must be ≥ 4 and a power of two.
- `SHW` (localparam): log2(WIDTH), the shift-amount width.

- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; accepted only when `busy`=0.
- `op`  in  4: operation code, sampled with `start`.
- `lt`  in  WIDTH: left operand, sampled with `start`.
- `rt`  in  WIDTH: right operand, sampled with `start`.
- `busy`  out  1: multi-cycle operation in progress.
- `done`  out  1: one-cycle pulse; result outputs are valid from this cycle onward.
- `out`  out  WIDTH: result (product low half for MULU, quotient for DIVU).
- `hi`  out  WIDTH: product high half (MULU), remainder (DIVU), 0 otherwise.
- `zero_flag`  out  1: `out`==0, updated with `done`.
- `ovf`  out  1: signed overflow for ADD/SUB, 0 otherwise.
- `dz`  out  1: divide by zero, DIVU only.

## Operation

- Opcodes:
  - 0000 AND.
  - 0001 OR.
  - 0100/0101 NOR.
  - 0010 ADD, 0110 SUB.
  - 0011/0111 SLT (signed; result 1 or 0).
  - 1000 SLL, 1001 SRL, 1010 SRA; shift amount is `rt[SHW-1:0]` and upper bits are ignored.
  - 1011 SLTU.
  - 1100 MULU.
  - 1101 DIVU.
  - 1110/1111 reserved: `out`=0, single-cycle.
- SLT must be correct when the sign bits differ (use the sign of `lt`) and when they are equal (use the sign of the difference). No overflow error is permitted.
- `ovf` for ADD: operand signs are equal and the sum sign differs. For SUB: operand signs differ and the result sign differs from `lt`.
- State machine has three states: IDLE, MUL, DIV.
- IDLE:
  - `start`=1 with a single-cycle op: register all outputs and pulse `done`; stay in IDLE.
  - `start`=1 with MULU: go to MUL, load counter = WIDTH.
  - `start`=1 with DIVU: go to DIV, load counter = WIDTH.
  - In both multi-cycle cases, latch the operands and clear accumulators.
- MUL: shift-add, one multiplier bit per cycle, 2·WIDTH-bit product accumulator.
- DIV: restoring division, one quotient bit per cycle.
- MUL/DIV exit: when the counter reaches 0, write `out`/`hi`/`zero_flag`/`dz`, pulse `done`, return to IDLE.
- DIVU by 0: runs the full latency; `out` = all ones, `hi` = `lt`, `dz`=1.
- Results and flags hold until the next `done`. `out`, `hi` and flags do not change while `busy`.
- `start` while `busy`=1 is ignored and not queued.
- Reset values: `busy`=0, `done`=0, `out`=0, `hi`=0, `zero_flag`=1, `ovf`=0, `dz`=0, state IDLE, counter 0.
- Reset mid-operation aborts with no `done` pulse; all outputs take their reset values on that edge.

## Timing

- Single-cycle ops: `start` sampled at edge N; `done`=1 and results valid after edge N+1. Latency 1; `busy` never asserts.
- MULU/DIVU: accepted at edge N; `busy`=1 after edges N+1 … N+WIDTH. After edge N+WIDTH+1: `done`=1, `busy`=0. Latency WIDTH+1.
- Back-to-back: `start` may be asserted in the same cycle `done` is high; throughput is 1 op/cycle for single-cycle ops.
- `done` is high for exactly one cycle per accepted request.
- `rst` has priority over `start` in the same cycle.

## Test plan

- ADD 0x7FFFFFFF + 0x00000001 → `out`=0x80000000, `ovf`=1, `zero_flag`=0, `done` one cycle after `start`, `busy` never high.
- SUB 5 − 5 → `out`=0, `zero_flag`=1. SLT 0xFFFFFFFF vs 1 → 1. SLTU 0xFFFFFFFF vs 1 → 0. SLT 0x80000000 vs 0x7FFFFFFF → 1.
- MULU 0xFFFFFFFF × 2 → `out`=0xFFFFFFFE, `hi`=1, `busy` high 32 cycles, `done` at N+33. A `start` pulsed mid-operation (ADD) is ignored and the MULU result is unaffected.
- DIVU 100 ÷ 7 → `out`=14, `hi`=2, `dz`=0. DIVU 100 ÷ 0 → `out`=0xFFFFFFFF, `hi`=100, `dz`=1, latency 33.
- `rst` on the 10th busy cycle of a MULU → next cycle `busy`=0 and `out`=0, no `done` pulse. A following ADD 3+4 → `out`=7 after 1 cycle.
- WIDTH=8 instance: SRA 0x80 by `rt`=0xFF (amount 7) → 0xFF. SRL 0x80 by 7 → 0x01. MULU 0xFF×0xFF → `out`=0x01, `hi`=0xFE, latency 9.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle logic/arith/shift/compare ops
// and iterative unsigned multiply (shift-add) and divide (restoring)
// behind a start/busy/done handshake.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] lt,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             zero_flag,
    output logic             ovf,
    output logic             dz
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = SHW + 1;
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [3:0] OP_MULU = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    opb;
    logic [2*WIDTH-1:0]  acc;

    logic [WIDTH-1:0]    sum_c;
    logic [WIDTH-1:0]    diff_c;
    logic [SHW-1:0]      sh_c;
    logic [WIDTH-1:0]    res_c;
    logic                ovf_c;

    logic [WIDTH:0]      madd_c;
    logic [2*WIDTH-1:0]  mul_next_c;
    logic [WIDTH:0]      dr_c;
    logic [WIDTH:0]      dsub_c;
    logic [2*WIDTH-1:0]  div_next_c;

    // Single-cycle result and signed overflow for the current request
    always_comb begin
        sum_c  = lt + rt;
        diff_c = lt - rt;
        sh_c   = rt[SHW-1:0];
        res_c  = '0;
        ovf_c  = 1'b0;
        case (op)
            4'b0000: res_c = lt & rt;
            4'b0001: res_c = lt | rt;
            4'b0100,
            4'b0101: res_c = ~(lt | rt);
            4'b0010: begin
                res_c = sum_c;
                ovf_c = (lt[MSB] == rt[MSB]) && (sum_c[MSB] != lt[MSB]);
            end
            4'b0110: begin
                res_c = diff_c;
                ovf_c = (lt[MSB] != rt[MSB]) && (diff_c[MSB] != lt[MSB]);
            end
            // differing signs: lt negative means less; equal signs: difference sign
            4'b0011,
            4'b0111: res_c = {{(WIDTH-1){1'b0}},
                              (lt[MSB] != rt[MSB]) ? lt[MSB] : diff_c[MSB]};
            4'b1000: res_c = lt << sh_c;
            4'b1001: res_c = lt >> sh_c;
            4'b1010: res_c = $signed(lt) >>> sh_c;
            4'b1011: res_c = {{(WIDTH-1){1'b0}}, (lt < rt)};
            default: res_c = '0;
        endcase
    end

    // One iteration of shift-add multiply and restoring divide on acc
    always_comb begin
        madd_c     = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        mul_next_c = {madd_c, acc[WIDTH-1:1]};
        dr_c       = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        dsub_c     = dr_c - {1'b0, opb};
        if (!dsub_c[WIDTH]) begin
            div_next_c = {dsub_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next_c = {dr_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM with registered results and handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            opb       <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out       <= '0;
            hi        <= '0;
            zero_flag <= 1'b1;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MULU) begin
                            state <= MUL;
                            cnt   <= CW'(WIDTH);
                            busy  <= 1'b1;
                            opb   <= lt;
                            acc   <= {{WIDTH{1'b0}}, rt};
                        end else if (op == OP_DIVU) begin
                            state <= DIV;
                            cnt   <= CW'(WIDTH);
                            busy  <= 1'b1;
                            opb   <= rt;
                            acc   <= {{WIDTH{1'b0}}, lt};
                        end else begin
                            out       <= res_c;
                            hi        <= '0;
                            zero_flag <= (res_c == '0);
                            ovf       <= ovf_c;
                            dz        <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next_c;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        out       <= mul_next_c[WIDTH-1:0];
                        hi        <= mul_next_c[2*WIDTH-1:WIDTH];
                        zero_flag <= (mul_next_c[WIDTH-1:0] == '0);
                        ovf       <= 1'b0;
                        dz        <= 1'b0;
                    end
                end
                DIV: begin
                    acc <= div_next_c;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        out       <= div_next_c[WIDTH-1:0];
                        hi        <= div_next_c[2*WIDTH-1:WIDTH];
                        zero_flag <= (div_next_c[WIDTH-1:0] == '0);
                        ovf       <= 1'b0;
                        dz        <= (opb == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
